// File: rtl/gf_mul_feed_2339.sv
// gf_mul_feed_2339: elastic multiplier stage feeding the Barrett reducer.
// Takes operand pairs over valid/ready and presents the exact unreduced
// product a*b. Out-of-range pairs are consumed but dropped, which raises
// a sticky error flag and bumps a drop counter.
module gf_mul_feed_2339 #(
    parameter int Q           = 2339,
    parameter int W_IN        = 12,
    parameter int W_OUT       = 23,
    parameter int PIPE_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_IN-1:0]  din_a,
    input  logic [W_IN-1:0]  din_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_OUT-1:0] dout_p,
    output logic             err_range,
    output logic [CNT_W-1:0] cnt_out,
    output logic [CNT_W-1:0] cnt_drop
);

    localparam logic [W_IN-1:0] Q_LIM = W_IN'(Q);

    logic [PIPE_STAGES-1:0] load;
    logic [PIPE_STAGES-1:0] v_q, v_d;
    logic [W_OUT-1:0]       s_q [PIPE_STAGES];
    logic [W_OUT-1:0]       s_d [PIPE_STAGES];
    logic                   err_range_q, err_range_d;
    logic [CNT_W-1:0]       cnt_out_q, cnt_out_d;
    logic [CNT_W-1:0]       cnt_drop_q, cnt_drop_d;

    logic                   accept;
    logic                   in_range;
    logic                   deliver;
    logic [W_OUT-1:0]       prod;

    // Load enables ripple back from the output, so a stage with a bubble
    // absorbs data even while everything downstream of it is stalled.
    always_comb begin
        logic chain;
        chain = out_ready;
        load  = '0;
        for (int i = PIPE_STAGES - 1; i >= 0; i--) begin
            chain   = !v_q[i] || chain;
            load[i] = chain;
        end
    end

    // Handshake decode, range check and the multiply feeding stage 0.
    always_comb begin
        in_ready = load[0];
        accept   = in_valid && in_ready;
        in_range = (din_a < Q_LIM) && (din_b < Q_LIM);
        deliver  = v_q[PIPE_STAGES-1] && out_ready;
        prod     = W_OUT'(din_a) * W_OUT'(din_b);
    end

    // Next state of the stage registers. Data only moves when a valid item
    // arrives, so bubbles never overwrite a held product.
    always_comb begin
        v_d = v_q;
        for (int i = 0; i < PIPE_STAGES; i++) begin
            s_d[i] = s_q[i];
        end
        if (load[0]) begin
            v_d[0] = accept && in_range;
            if (accept && in_range) begin
                s_d[0] = prod;
            end
        end
        for (int i = 1; i < PIPE_STAGES; i++) begin
            if (load[i]) begin
                v_d[i] = v_q[i-1];
                if (v_q[i-1]) begin
                    s_d[i] = s_q[i-1];
                end
            end
        end
    end

    // Sticky range error plus free-running wrap-around counters.
    always_comb begin
        err_range_d = err_range_q || (accept && !in_range);
        cnt_out_d   = cnt_out_q;
        cnt_drop_d  = cnt_drop_q;
        if (deliver) begin
            cnt_out_d = cnt_out_q + CNT_W'(1);
        end
        if (accept && !in_range) begin
            cnt_drop_d = cnt_drop_q + CNT_W'(1);
        end
    end

    // State registers; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q         <= '0;
            err_range_q <= 1'b0;
            cnt_out_q   <= '0;
            cnt_drop_q  <= '0;
            for (int i = 0; i < PIPE_STAGES; i++) begin
                s_q[i] <= '0;
            end
        end else begin
            v_q         <= v_d;
            err_range_q <= err_range_d;
            cnt_out_q   <= cnt_out_d;
            cnt_drop_q  <= cnt_drop_d;
            for (int i = 0; i < PIPE_STAGES; i++) begin
                s_q[i] <= s_d[i];
            end
        end
    end

    assign out_valid = v_q[PIPE_STAGES-1];
    assign dout_p    = s_q[PIPE_STAGES-1];
    assign err_range = err_range_q;
    assign cnt_out   = cnt_out_q;
    assign cnt_drop  = cnt_drop_q;

endmodule

// File: tb/tb_gf_mul_feed_2339.sv
// Testbench for gf_mul_feed_2339: directed vectors driven with a handshake
// driver, expected products queued on accept and popped by an output monitor.
module tb_gf_mul_feed_2339;

    localparam int Q     = 2339;
    localparam int W_IN  = 12;
    localparam int W_OUT = 23;
    localparam int N     = 2;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W_IN-1:0]  din_a;
    logic [W_IN-1:0]  din_b;
    logic             out_valid;
    logic             out_ready;
    logic [W_OUT-1:0] dout_p;
    logic             err_range;
    logic [CNT_W-1:0] cnt_out;
    logic [CNT_W-1:0] cnt_drop;

    int               errors;
    int               checks;
    logic [W_OUT-1:0] exp_q [$];
    int               exp_out;
    int               exp_drop;
    logic             exp_err;
    logic             stall_prev;
    logic [W_OUT-1:0] hold_data;
    logic             rand_ready_on;

    gf_mul_feed_2339 #(
        .Q(Q), .W_IN(W_IN), .W_OUT(W_OUT), .PIPE_STAGES(N), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .din_a(din_a), .din_b(din_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .dout_p(dout_p), .err_range(err_range),
        .cnt_out(cnt_out), .cnt_drop(cnt_drop)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Present one pair, wait for it to be taken, and queue its expected result.
    task automatic applyStimulus(input logic [W_IN-1:0] a, input logic [W_IN-1:0] b);
        logic got;
        got      = 1'b0;
        din_a    = a;
        din_b    = b;
        in_valid = 1'b1;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                if (a < W_IN'(Q) && b < W_IN'(Q)) begin
                    exp_q.push_back(W_OUT'(a) * W_OUT'(b));
                end else begin
                    exp_drop++;
                    exp_err = 1'b1;
                end
            end
        end
        if (!got) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Wait for all queued products to leave, then compare the counters.
    task automatic drainAndCheck(input string tag);
        for (int c = 0; c < 500 && exp_q.size() != 0; c++) begin
            @(negedge clk);
        end
        checkOutput({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_cnt_out"}, 32'(cnt_out), 32'(exp_out % 65536));
        checkOutput({tag, "_cnt_drop"}, 32'(cnt_drop), 32'(exp_drop % 65536));
        checkOutput({tag, "_err_range"}, 32'(err_range), 32'(exp_err));
    endtask

    // Count negedges from an accept until out_valid rises.
    task automatic checkLatency(input string tag);
        int lat;
        lat = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(N));
    endtask

    // Output monitor: hold stability, full-before-stall and in-order products.
    initial begin
        stall_prev = 1'b0;
        hold_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    checkOutput("hold_valid", 32'(out_valid), 32'd1);
                    checkOutput("hold_data", 32'(dout_p), 32'(hold_data));
                end
                if (!in_ready) begin
                    checkOutput("in_ready_low_only_when_full",
                                32'(exp_q.size() == N && !out_ready), 32'd1);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("spurious_product", 32'(dout_p), 32'hFFFF_FFFF);
                    end else begin
                        checkOutput("product", 32'(dout_p), 32'(exp_q.pop_front()));
                    end
                    exp_out++;
                end
                stall_prev = out_valid && !out_ready;
                hold_data  = dout_p;
            end
        end
    end

    // Random backpressure used by the soak phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready_on) out_ready = ($urandom_range(99) < 60);
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence.
    initial begin
        errors        = 0;
        checks        = 0;
        exp_out       = 0;
        exp_drop      = 0;
        exp_err       = 1'b0;
        rand_ready_on = 1'b0;
        void'($urandom(2339));
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        din_a     = '0;
        din_b     = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state.
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_dout_p", 32'(dout_p), 32'd0);
        checkOutput("rst_err_range", 32'(err_range), 32'd0);
        checkOutput("rst_cnt_out", 32'(cnt_out), 32'd0);
        checkOutput("rst_cnt_drop", 32'(cnt_drop), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

        // Single pair 3*4 = 12 with latency check.
        applyStimulus(12'd3, 12'd4);
        idle();
        checkLatency("single");
        checkOutput("single_value", 32'(dout_p), 32'd12);
        @(posedge clk);
        #1;
        checkOutput("single_one_cycle", 32'(out_valid), 32'd0);
        drainAndCheck("single");

        // Extremes: 2338*2338 = 5466244, 0*2338 = 0.
        applyStimulus(12'd2338, 12'd2338);
        applyStimulus(12'd0, 12'd2338);
        applyStimulus(12'd1, 12'd2338);
        idle();
        drainAndCheck("extreme");

        // Ten pairs back-to-back with a four-cycle stall.
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    applyStimulus(12'(100 + i), 12'(7 * i + 1));
                end
                idle();
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drainAndCheck("stream");
        checkOutput("stream_total", 32'(cnt_out), 32'd14);

        // Out-of-range pair dropped, next legal pair 5*7 = 35 delivered.
        applyStimulus(12'd2339, 12'd1);
        applyStimulus(12'd5, 12'd7);
        idle();
        drainAndCheck("range");
        checkOutput("range_cnt_drop_one", 32'(cnt_drop), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("range_err_sticky", 32'(err_range), 32'd1);

        // Fill the pipe under a stall, then reset asynchronously mid-cycle.
        out_ready = 1'b0;
        applyStimulus(12'd11, 12'd13);
        applyStimulus(12'd17, 12'd19);
        idle();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("async_rst_cnt_out", 32'(cnt_out), 32'd0);
        checkOutput("async_rst_cnt_drop", 32'(cnt_drop), 32'd0);
        checkOutput("async_rst_err_range", 32'(err_range), 32'd0);
        exp_q.delete();
        exp_out  = 0;
        exp_drop = 0;
        exp_err  = 1'b0;
        #2 rst_n  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(12'd6, 12'd7);
        idle();
        checkLatency("post_rst");
        checkOutput("post_rst_value", 32'(dout_p), 32'd42);
        drainAndCheck("post_rst");

        // Seeded random soak with random backpressure and ~5% illegal operands.
        rand_ready_on = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [W_IN-1:0] a;
            logic [W_IN-1:0] b;
            a = W_IN'($urandom_range(Q - 1));
            b = W_IN'($urandom_range(Q - 1));
            if ($urandom_range(99) < 5) begin
                if ($urandom_range(1) == 0) a = W_IN'($urandom_range(4095, Q));
                else b = W_IN'($urandom_range(4095, Q));
            end
            applyStimulus(a, b);
            if ($urandom_range(3) == 0) begin
                idle();
                @(posedge clk);
                #1;
            end
        end
        idle();
        rand_ready_on = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drainAndCheck("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
